// File: rtl/m14k_dataram_ctl.sv
// Data RAM sequencer/arbiter: hardware zero-initialisation of every way and line,
// then one-access-per-cycle arbitration between the core port and the refill engine.
module m14k_dataram_ctl #(
  parameter int ASSOC         = 2,
  parameter int LINE_IDX_SIZE = 9,
  parameter int WORD_WIDTH    = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     init_start_i,
  output logic                     init_busy_o,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [LINE_IDX_SIZE-1:0] core_idx_i,
  input  logic [ASSOC-1:0]         core_rmask_i,
  input  logic [4*ASSOC-1:0]       core_bmask_i,
  input  logic [WORD_WIDTH-1:0]    core_wdata_i,
  output logic                     core_gnt_o,
  input  logic                     fill_req_i,
  input  logic [LINE_IDX_SIZE-1:0] fill_idx_i,
  input  logic [4*ASSOC-1:0]       fill_bmask_i,
  input  logic [WORD_WIDTH-1:0]    fill_wdata_i,
  output logic                     fill_gnt_o,
  output logic [LINE_IDX_SIZE-1:0] ram_line_idx_o,
  output logic [ASSOC-1:0]         ram_rd_mask_o,
  output logic [4*ASSOC-1:0]       ram_wr_mask_o,
  output logic                     ram_rd_str_o,
  output logic                     ram_wr_str_o,
  output logic [WORD_WIDTH-1:0]    ram_wr_data_o,
  output logic                     ram_early_ce_o,
  output logic                     rd_valid_o
);

  localparam int WAY_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int MASK_W = 4 * ASSOC;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e                   state_q;
  logic [LINE_IDX_SIZE-1:0] idx_q;
  logic [WAY_W-1:0]         way_q;
  logic [1:0]               fill_wait_q;
  logic [1:0]               fill_wait_d;
  logic [LINE_IDX_SIZE-1:0] ram_line_idx_q;
  logic [ASSOC-1:0]         ram_rd_mask_q;
  logic [MASK_W-1:0]        ram_wr_mask_q;
  logic                     ram_rd_str_q;
  logic                     ram_wr_str_q;
  logic [WORD_WIDTH-1:0]    ram_wr_data_q;
  logic                     ram_early_ce_q;
  logic                     rd_valid_q;
  logic                     idle_s;
  logic                     core_gnt_s;
  logic                     fill_gnt_s;
  logic                     last_way_s;
  logic                     last_idx_s;

  // Byte-enable mask selecting all four bytes of one way.
  function automatic logic [MASK_W-1:0] way_mask(input logic [WAY_W-1:0] way);
    way_mask = '0;
    for (int w = 0; w < ASSOC; w++) begin
      way_mask[4*w +: 4] = (WAY_W'(w) == way) ? 4'hF : 4'h0;
    end
  endfunction

  // Grant decision and fill starvation counter next-state.
  always_comb begin
    idle_s     = resetn_i && (state_q == ST_IDLE) && !init_start_i;
    fill_gnt_s = idle_s && fill_req_i && ((fill_wait_q == 2'd3) || !core_req_i);
    core_gnt_s = idle_s && core_req_i && !fill_gnt_s;
    last_way_s = (way_q == WAY_W'(ASSOC - 1));
    last_idx_s = (idx_q == {LINE_IDX_SIZE{1'b1}});
    if (fill_gnt_s) begin
      fill_wait_d = 2'd0;
    end else if (fill_req_i && (fill_wait_q != 2'd3)) begin
      fill_wait_d = fill_wait_q + 2'd1;
    end else begin
      fill_wait_d = fill_wait_q;
    end
  end

  // Sequencer state, init counters and registered RAM-side outputs.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q        <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      idx_q          <= '0;
      way_q          <= '0;
      fill_wait_q    <= 2'd0;
      ram_line_idx_q <= '0;
      ram_rd_mask_q  <= '0;
      ram_wr_mask_q  <= '0;
      ram_rd_str_q   <= 1'b0;
      ram_wr_str_q   <= 1'b0;
      ram_wr_data_q  <= '0;
      ram_early_ce_q <= 1'b0;
      rd_valid_q     <= 1'b0;
    end else begin
      fill_wait_q    <= fill_wait_d;
      rd_valid_q     <= ram_rd_str_q;
      ram_rd_str_q   <= 1'b0;
      ram_wr_str_q   <= 1'b0;
      ram_early_ce_q <= 1'b0;
      ram_rd_mask_q  <= '0;
      ram_wr_mask_q  <= '0;
      case (state_q)
        ST_INIT: begin
          if (init_start_i) begin
            idx_q <= '0;
            way_q <= '0;
          end else begin
            ram_wr_str_q   <= 1'b1;
            ram_early_ce_q <= 1'b1;
            ram_line_idx_q <= idx_q;
            ram_wr_mask_q  <= way_mask(way_q);
            ram_wr_data_q  <= '0;
            if (last_way_s) begin
              way_q <= '0;
              idx_q <= idx_q + LINE_IDX_SIZE'(1);
              if (last_idx_s) begin
                state_q <= ST_IDLE;
              end
            end else begin
              way_q <= way_q + WAY_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (init_start_i) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            way_q   <= '0;
          end else if (fill_gnt_s) begin
            ram_wr_str_q   <= 1'b1;
            ram_early_ce_q <= 1'b1;
            ram_line_idx_q <= fill_idx_i;
            ram_wr_mask_q  <= fill_bmask_i;
            ram_wr_data_q  <= fill_wdata_i;
          end else if (core_gnt_s) begin
            if (!core_we_i) begin
              ram_rd_str_q   <= 1'b1;
              ram_early_ce_q <= 1'b1;
              ram_line_idx_q <= core_idx_i;
              ram_rd_mask_q  <= core_rmask_i;
            end else if (|core_bmask_i) begin
              ram_wr_str_q   <= 1'b1;
              ram_early_ce_q <= 1'b1;
              ram_line_idx_q <= core_idx_i;
              ram_wr_mask_q  <= core_bmask_i;
              ram_wr_data_q  <= core_wdata_i;
            end
            // A zero-byte-mask core write is acknowledged without touching the RAM.
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign init_busy_o    = (state_q == ST_INIT);
  assign core_gnt_o     = core_gnt_s;
  assign fill_gnt_o     = fill_gnt_s;
  assign ram_line_idx_o = ram_line_idx_q;
  assign ram_rd_mask_o  = ram_rd_mask_q;
  assign ram_wr_mask_o  = ram_wr_mask_q;
  assign ram_rd_str_o   = ram_rd_str_q;
  assign ram_wr_str_o   = ram_wr_str_q;
  assign ram_wr_data_o  = ram_wr_data_q;
  assign ram_early_ce_o = ram_early_ce_q;
  assign rd_valid_o     = rd_valid_q;

endmodule

// File: tb/tb_m14k_dataram_ctl.sv
// Bench for m14k_dataram_ctl (ASSOC=2, 8 lines): transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_m14k_dataram_ctl;
  localparam int ASSOC = 2;
  localparam int LIS   = 3;
  localparam int WW    = 32;
  localparam int NINIT = ASSOC * (1 << LIS);

  logic            clk = 1'b0;
  logic            resetn, init_start, init_busy;
  logic            core_req, core_we, core_gnt;
  logic [LIS-1:0]  core_idx, fill_idx, ram_line_idx;
  logic [ASSOC-1:0] core_rmask, ram_rd_mask;
  logic [4*ASSOC-1:0] core_bmask, fill_bmask, ram_wr_mask;
  logic [WW-1:0]   core_wdata, fill_wdata, ram_wr_data;
  logic            fill_req, fill_gnt;
  logic            ram_rd_str, ram_wr_str, ram_early_ce, rd_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  m14k_dataram_ctl #(
    .ASSOC(ASSOC), .LINE_IDX_SIZE(LIS), .WORD_WIDTH(WW), .INIT_ON_RESET(1)
  ) dut (
    .clk_i(clk), .resetn_i(resetn), .init_start_i(init_start), .init_busy_o(init_busy),
    .core_req_i(core_req), .core_we_i(core_we), .core_idx_i(core_idx),
    .core_rmask_i(core_rmask), .core_bmask_i(core_bmask), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .fill_req_i(fill_req), .fill_idx_i(fill_idx),
    .fill_bmask_i(fill_bmask), .fill_wdata_i(fill_wdata), .fill_gnt_o(fill_gnt),
    .ram_line_idx_o(ram_line_idx), .ram_rd_mask_o(ram_rd_mask), .ram_wr_mask_o(ram_wr_mask),
    .ram_rd_str_o(ram_rd_str), .ram_wr_str_o(ram_wr_str), .ram_wr_data_o(ram_wr_data),
    .ram_early_ce_o(ram_early_ce), .rd_valid_o(rd_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: init progress as a flat write count, arbitration from the priority rules.
  int         m_init = 1;
  int         m_n    = 0;
  int         m_fw   = 0;
  logic [LIS-1:0]     e_idx = '0;
  logic [ASSOC-1:0]   e_rm  = '0;
  logic [4*ASSOC-1:0] e_wm  = '0;
  logic [WW-1:0]      e_wd  = '0;
  logic e_rs = 1'b0, e_ws = 1'b0, e_rv = 1'b0;

  initial begin
    logic cg, fg, ir, iw;
    logic [LIS-1:0]     n_idx;
    logic [ASSOC-1:0]   n_rm;
    logic [4*ASSOC-1:0] n_wm;
    logic [WW-1:0]      n_wd;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_init_busy", 32'(init_busy), 32'(m_init != 0));
      chk("m_line_idx", 32'(ram_line_idx), 32'(e_idx));
      chk("m_rd_mask", 32'(ram_rd_mask), 32'(e_rm));
      chk("m_wr_mask", 32'(ram_wr_mask), 32'(e_wm));
      chk("m_rd_str", 32'(ram_rd_str), 32'(e_rs));
      chk("m_wr_str", 32'(ram_wr_str), 32'(e_ws));
      chk("m_early_ce", 32'(ram_early_ce), 32'(e_rs | e_ws));
      chk("m_wr_data", ram_wr_data, e_wd);
      chk("m_rd_valid", 32'(rd_valid), 32'(e_rv));
      cg = 1'b0; fg = 1'b0; ir = 1'b0; iw = 1'b0;
      n_idx = e_idx; n_wd = e_wd; n_rm = '0; n_wm = '0;
      if (!resetn) begin
        m_init = 1; m_n = 0; m_fw = 0; n_idx = '0; n_wd = '0;
      end else begin
        if (m_init != 0) begin
          if (init_start) begin
            m_n = 0;
          end else begin
            iw = 1'b1;
            n_idx = LIS'(m_n / ASSOC);
            n_wm = 8'(8'h0F << (4 * (m_n % ASSOC)));
            n_wd = '0;
            m_n++;
            if (m_n == NINIT) m_init = 0;
          end
        end else if (init_start) begin
          m_init = 1; m_n = 0;
        end else begin
          fg = fill_req && (m_fw == 3 || !core_req);
          cg = core_req && !fg;
          if (fg) begin
            iw = 1'b1; n_idx = fill_idx; n_wm = fill_bmask; n_wd = fill_wdata;
          end else if (cg && !core_we) begin
            ir = 1'b1; n_idx = core_idx; n_rm = core_rmask;
          end else if (cg && core_bmask != '0) begin
            iw = 1'b1; n_idx = core_idx; n_wm = core_bmask; n_wd = core_wdata;
          end
        end
        if (fg) m_fw = 0;
        else if (fill_req && m_fw < 3) m_fw++;
      end
      chk("m_core_gnt", 32'(core_gnt), 32'(cg));
      chk("m_fill_gnt", 32'(fill_gnt), 32'(fg));
      e_rv  = resetn ? e_rs : 1'b0;
      e_rs  = ir; e_ws = iw; e_rm = n_rm; e_wm = n_wm; e_idx = n_idx; e_wd = n_wd;
    end
  end

  // Directed scenarios.
  initial begin
    int cnt;
    logic [4:0] cg_tab, fg_tab;
    cg_tab = 5'b10111;
    fg_tab = 5'b01000;
    resetn = 1'b0; init_start = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_idx = '0; core_rmask = '0;
    core_bmask = '0; core_wdata = '0;
    fill_req = 1'b0; fill_idx = '0; fill_bmask = '0; fill_wdata = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy) cnt++;
      else break;
    end
    chk("reset_init_cycles", 32'(cnt), 32'd16);
    chk("last_init_idx", 32'(ram_line_idx), 32'd7);
    chk("last_init_mask", 32'(ram_wr_mask), 32'h0000_00F0);

    step();
    core_req = 1'b1; core_we = 1'b0; core_idx = 3'd5; core_rmask = 2'b11;
    @(negedge clk); chk("rd_gnt_N", 32'(core_gnt), 32'd1);
    step(); core_req = 1'b0;
    @(negedge clk); chk("rd_str_N1", 32'(ram_rd_str), 32'd1);
    chk("rd_idx_N1", 32'(ram_line_idx), 32'd5);
    chk("rd_valid_N1", 32'(rd_valid), 32'd0);
    step(); @(negedge clk); chk("rd_valid_N2", 32'(rd_valid), 32'd1);
    step(); @(negedge clk); chk("rd_valid_N3", 32'(rd_valid), 32'd0);

    step();
    core_req = 1'b1; core_we = 1'b0; core_idx = 3'd1; core_rmask = 2'b01;
    fill_req = 1'b1; fill_idx = 3'd6; fill_bmask = 8'hFF; fill_wdata = 32'hA5A5_0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("starve_core_gnt_%0d", c), 32'(core_gnt), 32'(cg_tab[c]));
      chk($sformatf("starve_fill_gnt_%0d", c), 32'(fill_gnt), 32'(fg_tab[c]));
      step();
    end
    core_req = 1'b0; fill_req = 1'b0;

    step();
    core_req = 1'b1; core_we = 1'b1; core_idx = 3'd2; core_bmask = 8'h3C; core_wdata = 32'hDEAD_BEEF;
    step();
    core_we = 1'b0; core_rmask = 2'b10;
    fill_req = 1'b1; fill_idx = 3'd3; fill_bmask = 8'h0F; fill_wdata = 32'h0000_1234;
    step();
    core_req = 1'b0;
    step();
    fill_req = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_idx = 3'd4; core_bmask = 8'h00; core_wdata = 32'h5555_AAAA;
    @(negedge clk); chk("zmask_gnt", 32'(core_gnt), 32'd1);
    step(); core_req = 1'b0;
    @(negedge clk); chk("zmask_wr_str", 32'(ram_wr_str), 32'd0);
    chk("zmask_early_ce", 32'(ram_early_ce), 32'd0);

    step(); init_start = 1'b1;
    step(); init_start = 1'b0;
    repeat (6) step();
    init_start = 1'b1;
    step(); init_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("restart_gap_wr_str", 32'(ram_wr_str), 32'd0);
      if (i == 1) begin
        chk("restart_first_idx", 32'(ram_line_idx), 32'd0);
        chk("restart_first_mask", 32'(ram_wr_mask), 32'h0000_000F);
      end
      if (init_busy) cnt++;
      else break;
    end
    chk("restart_init_cycles", 32'(cnt), 32'd16);

    step();
    core_req = 1'b1; core_we = 1'b1; core_idx = 3'd4; core_bmask = 8'hC3; core_wdata = 32'h0000_CAFE;
    @(negedge clk); chk("rst_wr_gnt", 32'(core_gnt), 32'd1);
    step(); core_req = 1'b0; resetn = 1'b0;
    @(negedge clk); chk("rst_wr_presented", 32'(ram_wr_str), 32'd1);
    step(); resetn = 1'b1;
    @(negedge clk);
    chk("rst_wr_str", 32'(ram_wr_str), 32'd0);
    chk("rst_early_ce", 32'(ram_early_ce), 32'd0);
    chk("rst_wr_mask", 32'(ram_wr_mask), 32'd0);
    chk("rst_line_idx", 32'(ram_line_idx), 32'd0);
    chk("rst_wr_data", ram_wr_data, 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_busy) cnt++;
      else break;
    end
    chk("post_reset_init_cycles", 32'(cnt), 32'd16);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
